memory_interface: RTL
=====================

MEMORY_INTERFACE -- requirements
Module: memory_interface

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, meaning extra clock cycles between request capture and completion (0..15).
REQ-002 SHALL have parameter DEPTH, default 256, meaning byte capacity of the internal storage array (power of two).
REQ-003 SHALL have port Clk  input  1  the single clock; all state changes on posedge.
REQ-004 SHALL have port Clr  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port MOV  input  1  memory operation valid, held high by the control unit until MOC is seen.
REQ-006 SHALL have port RW  input  1  1 = read, 0 = write.
REQ-007 SHALL have port Address  input  8  byte address, driven from MAR.
REQ-008 SHALL have port DataIn  input  32  write data from MDR, right-justified.
REQ-009 SHALL have port Size  input  2  00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-010 SHALL have port SE  input  1  sign-extend byte/halfword reads when 1, zero-extend when 0.
REQ-011 SHALL have port DataOut  output  32  registered read data toward MDR.
REQ-012 SHALL have port MOC  output  1  memory operation complete.
REQ-013 SHALL have port ALIGN_ERR  output  1  misaligned request flag, valid while MOC is high.

Function
REQ-014 SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-015 In IDLE with MOV=1 at posedge, SHALL capture RW, Address, DataIn, Size and SE, load the wait counter with WAIT_CYCLES, and go to BUSY.
REQ-016 In BUSY, SHALL decrement the counter each posedge; on the edge where the counter is 0, SHALL perform the access, set MOC=1 and go to DONE.
REQ-017 Total latency SHALL be exactly WAIT_CYCLES+1 posedges from the capture edge to MOC rising.
REQ-018 In DONE, SHALL hold MOC, DataOut and ALIGN_ERR stable while MOV=1; on a posedge with MOV=0, SHALL clear MOC and ALIGN_ERR and return to IDLE.
REQ-019 A new request SHALL be accepted only from IDLE; MOV must be sampled low at least once between requests (four-phase handshake).
REQ-020 Input changes during BUSY/DONE SHALL be ignored; captured values SHALL govern the access.
REQ-021 Storage SHALL be big-endian: the byte at Address is the most significant byte of a halfword or word.
REQ-022 Word access SHALL require Address[1:0]=00 and halfword access SHALL require Address[0]=0; otherwise ALIGN_ERR=1, no array write, DataOut unchanged.
REQ-023 Byte/halfword reads SHALL be right-justified in DataOut, extended per SE.
REQ-024 Byte/halfword writes SHALL store DataIn[7:0] / DataIn[15:0] and leave other bytes unchanged.
REQ-025 Address plus access width SHALL wrap modulo DEPTH (aligned accesses never straddle).

Reset
REQ-026 On Clr=1, immediately and asynchronously, SHALL force state IDLE, counter 0, MOC=0, ALIGN_ERR=0, DataOut=0.
REQ-027 Clr asserted during BUSY SHALL abort the request; no array location SHALL be modified.
REQ-028 The storage array SHALL NOT be cleared by Clr; the bench preloads it hierarchically.

Structure
REQ-029 Size encodings, FSM state encodings and the default WAIT_CYCLES SHALL live in a shared package used by the control unit and this block.
REQ-030 The byte-lane alignment and extension logic SHALL be one sub-module, mem_lane_align, purely combinational; FSM and storage SHALL remain in memory_interface.

Verification
REQ-031 Word write then read, WAIT_CYCLES=2: write 0xDEADBEEF at 0x04, then read 0x04 -> MOC rises 3 edges after each capture; DataOut=0xDEADBEEF; byte 0x04=0xDE.
REQ-032 Byte read with sign: mem[0x05]=0xAD, Size=00, SE=1 -> DataOut=0xFFFFFFAD; with SE=0 -> 0x000000AD.
REQ-033 Halfword write 0x1234 at 0x06 over 0xDEADBEEF at 0x04 -> word read 0x04 returns 0xDEAD1234.
REQ-034 Misaligned word read at 0x02 -> MOC rises at normal latency with ALIGN_ERR=1, DataOut unchanged, memory unchanged.
REQ-035 Handshake: MOV held high 5 extra cycles after MOC -> MOC stays 1, no second access; MOV low -> MOC=0 on next edge; next MOV accepted the edge after.
REQ-036 Reset mid-operation: write 0x11223344 at 0x08, Clr pulsed in BUSY -> MOC=0 immediately, mem[0x08..0x0B] unchanged, FSM in IDLE.

Source files
------------

// File: rtl/memory_interface_pkg.sv
// Shared definitions for the memory interface and the control unit that drives it:
// access-size encodings, FSM state encodings and the default wait-state count.
package memory_interface_pkg;

    localparam int WAIT_CYCLES_DEFAULT = 2;
    localparam int CNT_W               = 4;

    typedef enum logic [1:0] {
        SIZE_BYTE     = 2'b00,
        SIZE_HALF     = 2'b01,
        SIZE_WORD     = 2'b10,
        SIZE_WORD_ALT = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Halfwords need an even address, words (including encoding 11) a multiple of four.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return offset[0];
            default:   return |offset;
        endcase
    endfunction

endpackage

// File: rtl/memory_interface_if.sv
// Bus between the control unit (master, MAR/MDR side) and the memory interface (slave).
interface memory_interface_if;

    logic        MOV;
    logic        RW;
    logic [7:0]  Address;
    logic [31:0] DataIn;
    logic [1:0]  Size;
    logic        SE;
    logic [31:0] DataOut;
    logic        MOC;
    logic        ALIGN_ERR;

    modport master (
        output MOV, RW, Address, DataIn, Size, SE,
        input  DataOut, MOC, ALIGN_ERR
    );

    modport slave (
        input  MOV, RW, Address, DataIn, Size, SE,
        output DataOut, MOC, ALIGN_ERR
    );

endinterface

// File: rtl/memory_interface_lane_align.sv
// Big-endian byte-lane steering: picks and extends read data from an aligned 32-bit
// group and builds per-byte write enables and lane data. Purely combinational.
module mem_lane_align
    import memory_interface_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_se,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_rword,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic [31:0] o_wword,
    output logic [3:0]  o_wbe,
    output logic        o_align_err
);

    logic [7:0]  w_rbyte;
    logic [15:0] w_rhalf;

    assign o_align_err = is_misaligned(i_size, i_offset);
    assign w_rhalf     = i_offset[1] ? i_rword[15:0] : i_rword[31:16];

    // Lane 0 (lowest address) sits in bits 31:24; o_wbe[3] enables that lane.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        w_rbyte = i_rword[31:24];
        o_rdata = i_rword;
        o_wword = i_wdata;
        o_wbe   = 4'b1111;
        case (i_offset)
            2'd0:    w_rbyte = i_rword[31:24];
            2'd1:    w_rbyte = i_rword[23:16];
            2'd2:    w_rbyte = i_rword[15:8];
            default: w_rbyte = i_rword[7:0];
        endcase
        case (i_size)
            SIZE_BYTE: begin
                o_rdata = {{24{i_se & w_rbyte[7]}}, w_rbyte};
                o_wword = {4{i_wdata[7:0]}};
                o_wbe   = 4'b1000 >> i_offset;
            end
            SIZE_HALF: begin
                o_rdata = {{16{i_se & w_rhalf[15]}}, w_rhalf};
                o_wword = {2{i_wdata[15:0]}};
                o_wbe   = i_offset[1] ? 4'b0011 : 4'b1100;
            end
            default: ;
        endcase
        if (o_align_err) begin
            o_wbe = 4'b0000;
        end
    end

endmodule

// File: rtl/memory_interface.sv
// Byte-addressed memory with a fixed wait-state count and a four-phase MOV/MOC handshake.
// Requests are captured in IDLE; the access happens after WAIT_CYCLES extra edges.
module memory_interface
    import memory_interface_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT,
    parameter int DEPTH       = 256
) (
    input logic               Clk,
    input logic               Clr,
    memory_interface_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_rw;
    logic [7:0]         r_addr;
    logic [31:0]        r_wdata;
    logic [1:0]         r_size;
    logic               r_se;
    logic [31:0]        r_dout;
    logic               r_moc;
    logic               r_align_err;
    logic [7:0]         r_mem [DEPTH];

    logic [AW-1:0]      w_idx [4];
    logic [31:0]        w_rword;
    logic [31:0]        w_rdata;
    logic [31:0]        w_wword;
    logic [3:0]         w_wbe;
    logic               w_align_err;
    logic               w_access;

    // Aligned accesses stay inside one 4-byte group, so wrap is just the index width.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_idx[k] = AW'({r_addr[7:2], 2'(k)});
        end
    end

    assign w_rword  = {r_mem[w_idx[0]], r_mem[w_idx[1]], r_mem[w_idx[2]], r_mem[w_idx[3]]};
    assign w_access = (r_state == ST_BUSY) && (r_cnt == '0);

    mem_lane_align u_lane_align (
        .i_size      (r_size),
        .i_se        (r_se),
        .i_offset    (r_addr[1:0]),
        .i_rword     (w_rword),
        .i_wdata     (r_wdata),
        .o_rdata     (w_rdata),
        .o_wword     (w_wword),
        .o_wbe       (w_wbe),
        .o_align_err (w_align_err)
    );

    // NOTE: the storage array has no reset; contents survive Clr and map onto plain RAM.
    always_ff @(posedge Clk) begin
        if (w_access && !r_rw) begin
            for (int k = 0; k < 4; k++) begin
                if (w_wbe[3-k]) begin
                    r_mem[w_idx[k]] <= w_wword[8*(3-k) +: 8];
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_rw        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_size      <= '0;
            r_se        <= 1'b0;
            r_dout      <= '0;
            r_moc       <= 1'b0;
            r_align_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.MOV) begin
                        r_rw    <= bus.RW;
                        r_addr  <= bus.Address;
                        r_wdata <= bus.DataIn;
                        r_size  <= bus.Size;
                        r_se    <= bus.SE;
                        r_cnt   <= CNT_W'(WAIT_CYCLES);
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == '0) begin
                        r_moc       <= 1'b1;
                        r_align_err <= w_align_err;
                        if (r_rw && !w_align_err) begin
                            r_dout <= w_rdata;
                        end
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    // Completion is held until the requester drops MOV.
                    if (!bus.MOV) begin
                        r_moc       <= 1'b0;
                        r_align_err <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.DataOut   = r_dout;
    assign bus.MOC       = r_moc;
    assign bus.ALIGN_ERR = r_align_err;

endmodule
